// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch FSM states, reset PC and PC increment
package cpu_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_t;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam int PC_INC = 4;
endpackage

// File: rtl/redirect_buf.sv
// redirect_buf: pending flush/branch redirects; in flush/flush_pc/branch_taken/branch_target/take_*, out *_any/*_nxt
module redirect_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_pc,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             take_flush,
  input  logic             take_br,
  output logic             flush_any,
  output logic [WIDTH-1:0] flush_nxt,
  output logic             br_any,
  output logic [WIDTH-1:0] br_nxt
);
  logic             flush_pend_q, flush_pend_d, br_pend_q, br_pend_d;
  logic [WIDTH-1:0] flush_tgt_q, flush_tgt_d, br_tgt_q, br_tgt_d;
  logic             br_cap;
  assign flush_any = flush | flush_pend_q;
  assign flush_nxt = flush ? flush_pc : flush_tgt_q;
  assign br_any    = branch_taken | br_pend_q;
  assign br_nxt    = branch_taken ? branch_target : br_tgt_q;
  // a branch is dropped whenever a flush is pending or arriving
  assign br_cap    = branch_taken & ~flush & ~flush_pend_q;
  always_comb begin
    flush_pend_d = take_flush ? 1'b0 : flush ? 1'b1 : flush_pend_q;
    flush_tgt_d  = flush ? flush_pc : flush_tgt_q;
    br_pend_d    = (flush | take_flush | take_br) ? 1'b0 : br_cap ? 1'b1 : br_pend_q;
    br_tgt_d     = br_cap ? branch_target : br_tgt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
      flush_tgt_q  <= '0;
      br_pend_q    <= 1'b0;
      br_tgt_q     <= '0;
    end else begin
      flush_pend_q <= flush_pend_d;
      flush_tgt_q  <= flush_tgt_d;
      br_pend_q    <= br_pend_d;
      br_tgt_q     <= br_tgt_d;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer; in redirects/stall/bus handshake, out inst_req/inst_addr/pc_f/inst_f/inst_valid_f
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_pc,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] inst_f,
  output logic             inst_valid_f
);
  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, inst_q, inst_d;
  logic             req_q, valid_q;
  logic             take_flush, take_br, flush_any, br_any;
  logic [WIDTH-1:0] flush_nxt, br_nxt;
  redirect_buf #(.WIDTH(WIDTH)) u_redirect (
    .clk(clk), .rst(rst),
    .flush(flush), .flush_pc(flush_pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .take_flush(take_flush), .take_br(take_br),
    .flush_any(flush_any), .flush_nxt(flush_nxt),
    .br_any(br_any), .br_nxt(br_nxt)
  );
  assign inst_addr    = pc_q;
  assign pc_f         = pc_q;
  assign inst_f       = inst_q;
  assign inst_req     = req_q & ~rst;
  assign inst_valid_f = valid_q & ~rst;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    take_flush = 1'b0;
    take_br    = 1'b0;
    case (state_q)
      REQ:  state_d = inst_addr_ok ? WAIT : REQ;
      WAIT: if (inst_data_ok) begin
        take_flush = flush_any;
        state_d    = flush_any ? REQ : HOLD;
        pc_d       = flush_any ? flush_nxt : pc_q;
        inst_d     = flush_any ? inst_q : inst_rdata;
      end
      HOLD: begin
        take_flush = flush;
        take_br    = ~flush & ~stall_f;
        state_d    = (flush | ~stall_f) ? REQ : HOLD;
        pc_d       = flush ? flush_pc : ~stall_f ? (br_any ? br_nxt : pc_q + WIDTH'(PC_INC)) : pc_q;
      end
      default: state_d = REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      req_q   <= state_d == REQ;
      valid_q <= state_d == HOLD;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random fetch sequences checked against a fetch-level reference model
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0, branch_taken = 1'b0, flush = 1'b0;
  logic [31:0] branch_target = '0, flush_pc = '0;
  logic        inst_req, inst_valid_f;
  logic [31:0] inst_addr, pc_f, inst_f;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  int n_cmp = 0, n_err = 0;
  logic        d_rst, d_flush, d_br, d_stall, d_aok;
  logic [31:0] d_fpc, d_bt;
  int          d_lat;
  logic [31:0] m_pc, m_inst, m_ft, m_bt;
  logic        m_hold, m_out, m_fp, m_bp;
  int          cnt;
  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall_f(stall_f),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .flush(flush), .flush_pc(flush_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .pc_f(pc_f), .inst_f(inst_f), .inst_valid_f(inst_valid_f)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'hbfc00000 ? 32'h24020001 : {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    d_rst = 0; d_flush = 0; d_br = 0; d_stall = 0; d_aok = 1; d_lat = 1;
    d_fpc = '0; d_bt = '0;
  endtask
  task automatic cyc();
    logic aok, dok;
    chk("req", {31'b0, inst_req}, {31'b0, !rst && !m_out && !m_hold});
    chk("valid", {31'b0, inst_valid_f}, {31'b0, !rst && m_hold});
    chk("addr", inst_addr, m_pc);
    chk("pc_f", pc_f, m_pc);
    chk("inst_f", inst_f, m_inst);
    aok = !d_rst && !m_out && !m_hold && d_aok;
    dok = !d_rst && m_out && cnt == 0;
    rst = d_rst; flush = d_flush; flush_pc = d_fpc;
    branch_taken = d_br; branch_target = d_bt; stall_f = d_stall;
    inst_addr_ok = aok; inst_data_ok = dok;
    inst_rdata = dok ? mem(m_pc) : $urandom;
    if (d_rst) begin
      m_pc = 32'hbfc00000; m_inst = '0; m_hold = 0; m_out = 0; m_fp = 0; m_bp = 0; cnt = 0;
    end else if (m_hold) begin
      if (d_flush) begin
        m_pc = d_fpc; m_hold = 0; m_fp = 0; m_bp = 0;
      end else if (!d_stall) begin
        m_pc = d_br ? d_bt : m_bp ? m_bt : m_pc + 32'd4; m_hold = 0; m_bp = 0;
      end else if (d_br) begin
        m_bp = 1; m_bt = d_bt;
      end
    end else if (dok && (d_flush || m_fp)) begin
      m_pc = d_flush ? d_fpc : m_ft; m_fp = 0; m_bp = 0; m_out = 0;
    end else begin
      if (m_out && !dok) cnt--;
      if (dok) begin m_inst = mem(m_pc); m_hold = 1; m_out = 0; end
      if (aok) begin m_out = 1; cnt = d_lat - 1; end
      if (d_flush) begin m_fp = 1; m_ft = d_fpc; m_bp = 0; end
      else if (d_br && !m_fp) begin m_bp = 1; m_bt = d_bt; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    m_pc = 32'hbfc00000; m_inst = '0; m_ft = '0; m_bt = '0;
    m_hold = 0; m_out = 0; m_fp = 0; m_bp = 0; cnt = 0;
    @(posedge clk);
    @(negedge clk);
    idle(); d_rst = 1;
    cyc(); cyc();
    idle();
    chk("rst_addr", inst_addr, 32'hbfc00000);
    cyc(); cyc();
    chk("first_inst", inst_f, 32'h24020001);
    chk("first_valid", {31'b0, inst_valid_f}, 32'd1);
    d_stall = 1;
    repeat (4) cyc();
    chk("stall_pc", pc_f, 32'hbfc00000);
    chk("stall_req", {31'b0, inst_req}, 32'd0);
    d_stall = 0;
    cyc();
    chk("seq_addr", inst_addr, 32'hbfc00004);
    cyc(); cyc(); cyc();
    chk("ds_addr", inst_addr, 32'hbfc00008);
    d_br = 1; d_bt = 32'hbfc00100;
    cyc();
    idle();
    cyc();
    chk("ds_valid_pc", pc_f, 32'hbfc00008);
    cyc();
    chk("br_addr", inst_addr, 32'hbfc00100);
    d_lat = 2;
    cyc();
    d_flush = 1; d_fpc = 32'hbfc00380;
    cyc();
    idle();
    cyc();
    chk("flush_novalid", {31'b0, inst_valid_f}, 32'd0);
    chk("flush_addr", inst_addr, 32'hbfc00380);
    cyc(); cyc();
    d_flush = 1; d_fpc = 32'hbfc00400; d_br = 1; d_bt = 32'hbfc00500;
    cyc();
    idle();
    chk("flush_beats_br", inst_addr, 32'hbfc00400);
    cyc();
    d_rst = 1;
    cyc();
    idle();
    chk("rst_wait_addr", inst_addr, 32'hbfc00000);
    cyc();
    d_flush = 1; d_fpc = 32'hfffffffc;
    cyc();
    idle();
    chk("wrap_pre", inst_addr, 32'hfffffffc);
    cyc(); cyc(); cyc();
    chk("wrap_addr", inst_addr, 32'h00000000);
    for (int i = 0; i < 3000; i++) begin
      d_rst   = ($urandom % 200) == 0;
      d_flush = ($urandom % 10) == 0;
      d_fpc   = $urandom & ~32'h3;
      d_br    = ($urandom % 4) == 0;
      d_bt    = $urandom & ~32'h3;
      d_stall = ($urandom % 3) == 0;
      d_aok   = ($urandom % 2) == 0;
      d_lat   = 1 + int'($urandom % 3);
      cyc();
    end
    idle();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the CPU's IF stage. Owns the fetch PC register, issues single-outstanding requests on the instruction SRAM-like bus and holds the returned instruction for decode under `stall_f`. It also applies two kinds of redirect:
- branch redirect: after the delay-slot instruction is consumed;
- exception/ERET flush: immediately, squashing the in-flight fetch.

Sits between the hazard unit / decode / exception logic and the instruction bus interface.

## Interface
- `WIDTH`, 32: address/data width.
- `RESET_PC`, 32'hbfc00000: PC value after reset.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall_f` in 1: decode cannot accept; hold the current instruction.
- `branch_taken` in 1: taken branch/jump resolved in decode.
- `branch_target` in WIDTH: branch/jump target.
- `flush` in 1: exception or ERET redirect.
- `flush_pc` in WIDTH: handler or EPC address.
- `inst_req` out 1: bus request.
- `inst_addr` out WIDTH: request address; always equals `pc_f`.
- `inst_addr_ok` in 1: address accepted; may be asserted in the same cycle as `inst_req`.
- `inst_data_ok` in 1: read data valid; at least 1 cycle after `inst_addr_ok`.
- `inst_rdata` in WIDTH: read data.
- `pc_f` out WIDTH: PC of the current fetch.
- `inst_f` out WIDTH: held instruction.
- `inst_valid_f` out 1: `inst_f`/`pc_f` valid for decode.

## Operation
- States:
  - REQ: `inst_req`=1.
  - WAIT: address accepted, awaiting data.
  - HOLD: `inst_valid_f`=1.
- At most one outstanding request.
- Reset: state=REQ, `pc_f`=RESET_PC, `inst_f`=0, pending flags cleared. While `rst`=1, `inst_req`=0 and `inst_valid_f`=0.
- The instruction bus is reset in the same cycle; a `data_ok` for a pre-reset request never arrives.
- REQ: `inst_addr` is stable until `inst_addr_ok`. On `inst_addr_ok` → WAIT.
- WAIT, on `inst_data_ok`:
  - if `flush_pend` or `flush` is set: `pc_f`←flush target, clear `flush_pend`, → REQ. The returned data is discarded.
  - otherwise: `inst_f`←`inst_rdata`, → HOLD.
- HOLD:
  - `flush`: `pc_f`←`flush_pc`, → REQ; the held instruction is squashed.
  - else if `stall_f`=0 (consume): `pc_f`←branch target if `br_pend` or `branch_taken`, else `pc_f`+4; clear `br_pend`; → REQ.
  - else: stay in HOLD.
- Redirect capture (any state, when not applied immediately):
  - `flush` → `flush_pend`=1, `flush_tgt`←`flush_pc`; clears `br_pend`.
  - `branch_taken` → `br_pend`=1, `br_tgt`←`branch_target`; ignored if a flush is pending or present.
  - A later event overwrites an earlier one of the same kind.
- In REQ/WAIT, a flush cannot change `inst_addr` mid-request. It is recorded and applied at `data_ok`.
- A branch never discards the in-flight/held instruction, which is the delay slot.
- Priority: `rst` > `flush` > `branch_taken` > sequential.
- Arithmetic: `pc_f`+4 wraps modulo 2^WIDTH. Targets are loaded unmodified; alignment faults are detected downstream.

## Timing
- Best-case throughput: 1 instruction per 3 cycles (REQ with same-cycle addr_ok → WAIT → HOLD consume → REQ).
- `inst_valid_f` rises the cycle after `inst_data_ok`.
- Flush in HOLD: `inst_valid_f`=0 next cycle, and `inst_addr`=`flush_pc` next cycle.
- Flush in REQ/WAIT: the new address appears the cycle after the outstanding `data_ok`.
- Flush and `data_ok` in the same cycle: the data is discarded and the new address appears next cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from bus inputs to `inst_req`/`inst_addr`.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum (REQ, WAIT, HOLD);
  - `RESET_PC` constant;
  - `PC_INC` = 4.
- One sub-module, `redirect_buf`: the `flush_pend`/`br_pend` registers with their targets, the priority logic and the clear inputs.
- The FSM and PC register stay in `fetch_ctrl`.

## Test plan
- Reset release, addr_ok same cycle, data_ok 1 cycle later with rdata=0x24020001 → `inst_addr`=0xbfc00000 first cycle; `inst_valid_f`=1 with `inst_f`=0x24020001; next `inst_addr`=0xbfc00004.
- `stall_f`=1 for 4 cycles in HOLD → `inst_f`/`pc_f` unchanged and no `inst_req`. Release → next address is `pc_f`+4.
- `branch_taken` with target 0xbfc00100 while fetching the delay slot at 0xbfc00008 → the delay slot is delivered, then the next request is to 0xbfc00100.
- `flush` with `flush_pc`=0xbfc00380 during WAIT → the returned data is never valid; the next request is to 0xbfc00380.
- `flush` and `branch_taken` in the same cycle → the branch is ignored and the fetch goes to `flush_pc`.
- `rst` asserted in WAIT, then `pc_f`=0xffff_fffc consumed → reset restarts at 0xbfc00000, and wrap produces 0x00000000.
